// File: rtl/sync_fifo_ext.sv
// sync_fifo_ext: single-clock FIFO for the UART TX/RX data paths.
// Supports show-ahead or registered read data, a fill-level output, live
// almost-full / almost-empty thresholds, synchronous flush and sticky
// overflow / underflow flags. DEPTH need not be a power of two.
module sync_fifo_ext #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int SHOW_AHEAD = 1,
    parameter int LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic [LVL_W-1:0]      level,
    input  logic [LVL_W-1:0]      af_thresh,
    input  logic [LVL_W-1:0]      ae_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int                PTR_W     = $clog2(DEPTH);
    localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic wrAccept;
    logic rdAccept;
    logic wrReject;
    logic rdReject;

    // Status flags are derived purely from the level register; thresholds are live.
    always_comb begin
        full         = (level_q == DEPTH_LVL);
        empty        = (level_q == '0);
        almost_full  = (level_q >= af_thresh);
        almost_empty = (level_q <= ae_thresh);
        level        = level_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    // Accept/reject decisions: flush suppresses both accesses and their error reporting.
    always_comb begin
        wrAccept = wr_en && !full  && !flush;
        rdAccept = rd_en && !empty && !flush;
        wrReject = wr_en && full   && !flush;
        rdReject = rd_en && empty  && !flush;
    end

    // Next-state for pointers, level and sticky error flags.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
        end else begin
            if (wrAccept) begin
                wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + PTR_W'(1);
            end
            if (rdAccept) begin
                rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + PTR_W'(1);
            end
            case ({wrAccept, rdAccept})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end

        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wrReject) begin
            overflow_d = 1'b1;
        end
        if (rdReject) begin
            underflow_d = 1'b1;
        end
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wrAccept) begin
            mem_q[wrPtr_q] <= din;
        end
    end

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            // Head entry is presented directly; valid whenever something is stored.
            always_comb begin
                dout       = mem_q[rdPtr_q];
                dout_valid = !empty;
            end
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  doutValid_q;

            // Registered read data captured on each accepted read; flush only drops the valid pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q      <= '0;
                    doutValid_q <= 1'b0;
                end else begin
                    doutValid_q <= rdAccept;
                    if (rdAccept) begin
                        dout_q <= mem_q[rdPtr_q];
                    end
                end
            end

            always_comb begin
                dout       = dout_q;
                dout_valid = doutValid_q;
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Testbench for sync_fifo_ext: three instances cover the 16-deep show-ahead
// build, a 5-deep build for non-power-of-two wrap, and a registered-read build.
module tb_sync_fifo_ext;

    logic clk = 1'b0;
    logic rstN;

    int checks = 0;
    int errors = 0;

    // Instance A: DEPTH=16, show-ahead
    logic       aFlush, aWr, aRd, aClr;
    logic [7:0] aDin, aDout;
    logic [4:0] aAf, aAe, aLevel;
    logic       aDv, aFull, aEmpty, aAfO, aAeO, aOvf, aUnf;

    // Instance B: DEPTH=5, show-ahead
    logic       bFlush, bWr, bRd, bClr;
    logic [7:0] bDin, bDout;
    logic [2:0] bAf, bAe, bLevel;
    logic       bDv, bFull, bEmpty, bAfO, bAeO, bOvf, bUnf;

    // Instance C: DEPTH=4, registered read
    logic       cFlush, cWr, cRd, cClr;
    logic [7:0] cDin, cDout;
    logic [2:0] cAf, cAe, cLevel;
    logic       cDv, cFull, cEmpty, cAfO, cAeO, cOvf, cUnf;

    sync_fifo_ext #(.DATA_WIDTH(8), .DEPTH(16), .SHOW_AHEAD(1)) uDutA (
        .clk(clk), .rst_n(rstN), .flush(aFlush), .wr_en(aWr), .din(aDin),
        .rd_en(aRd), .dout(aDout), .dout_valid(aDv), .full(aFull), .empty(aEmpty),
        .level(aLevel), .af_thresh(aAf), .ae_thresh(aAe), .almost_full(aAfO),
        .almost_empty(aAeO), .overflow(aOvf), .underflow(aUnf), .clr_err(aClr)
    );

    sync_fifo_ext #(.DATA_WIDTH(8), .DEPTH(5), .SHOW_AHEAD(1)) uDutB (
        .clk(clk), .rst_n(rstN), .flush(bFlush), .wr_en(bWr), .din(bDin),
        .rd_en(bRd), .dout(bDout), .dout_valid(bDv), .full(bFull), .empty(bEmpty),
        .level(bLevel), .af_thresh(bAf), .ae_thresh(bAe), .almost_full(bAfO),
        .almost_empty(bAeO), .overflow(bOvf), .underflow(bUnf), .clr_err(bClr)
    );

    sync_fifo_ext #(.DATA_WIDTH(8), .DEPTH(4), .SHOW_AHEAD(0)) uDutC (
        .clk(clk), .rst_n(rstN), .flush(cFlush), .wr_en(cWr), .din(cDin),
        .rd_en(cRd), .dout(cDout), .dout_valid(cDv), .full(cFull), .empty(cEmpty),
        .level(cLevel), .af_thresh(cAf), .ae_thresh(cAe), .almost_full(cAfO),
        .almost_empty(cAeO), .overflow(cOvf), .underflow(cUnf), .clr_err(cClr)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fillA(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            aWr  = 1'b1;
            aDin = 8'(base + i);
            tick();
        end
        aWr = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        #3;
        checks++; if (aLevel !== 5'd0) begin errors++; $display("[TB] FAIL reset_level got %0d want 0", aLevel); end
        checks++; if (aEmpty !== 1'b1 || aFull !== 1'b0) begin errors++; $display("[TB] FAIL reset_empty_full got %b%b want 10", aEmpty, aFull); end
        checks++; if (aAeO !== 1'b1 || aAfO !== 1'b0) begin errors++; $display("[TB] FAIL reset_almost got ae=%b af=%b want ae=1 af=0", aAeO, aAfO); end
        checks++; if (aOvf !== 1'b0 || aUnf !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got ovf=%b unf=%b want 0 0", aOvf, aUnf); end
        checks++; if (cDout !== 8'h00 || cDv !== 1'b0) begin errors++; $display("[TB] FAIL reset_regdout got %h/%b want 00/0", cDout, cDv); end
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_fill_thresholds();
        logic expAe, expAf;
        for (int i = 1; i <= 16; i++) begin
            aWr  = 1'b1;
            aDin = 8'(i);
            tick();
            expAe = (i <= 3);
            expAf = (i >= 12);
            checks++; if (aLevel !== 5'(i)) begin errors++; $display("[TB] FAIL fill_level got %0d want %0d", aLevel, i); end
            checks++; if (aAeO !== expAe || aAfO !== expAf) begin errors++; $display("[TB] FAIL thresh_lvl%0d got ae=%b af=%b want ae=%b af=%b", i, aAeO, aAfO, expAe, expAf); end
        end
        aWr = 1'b0;
        checks++; if (aFull !== 1'b1 || aEmpty !== 1'b0) begin errors++; $display("[TB] FAIL fill_full got full=%b empty=%b want 1 0", aFull, aEmpty); end
    endtask

    task automatic test_overflow();
        aWr  = 1'b1;
        aDin = 8'hAA;
        tick();
        aWr  = 1'b0;
        checks++; if (aOvf !== 1'b1) begin errors++; $display("[TB] FAIL overflow_set got %b want 1", aOvf); end
        checks++; if (aLevel !== 5'd16) begin errors++; $display("[TB] FAIL overflow_level got %0d want 16", aLevel); end
        checks++; if (aDout !== 8'h01) begin errors++; $display("[TB] FAIL overflow_head got %h want 01", aDout); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            checks++; if (aDout !== 8'(i) || aDv !== 1'b1) begin errors++; $display("[TB] FAIL drain_data got %h/%b want %h/1", aDout, aDv, 8'(i)); end
            aRd = 1'b1;
            tick();
        end
        aRd = 1'b0;
        checks++; if (aEmpty !== 1'b1 || aLevel !== 5'd0 || aDv !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty got empty=%b level=%0d dv=%b want 1 0 0", aEmpty, aLevel, aDv); end
        checks++; if (aUnf !== 1'b0) begin errors++; $display("[TB] FAIL drain_nounf got %b want 0", aUnf); end
        aRd = 1'b1;
        tick();
        aRd = 1'b0;
        checks++; if (aUnf !== 1'b1 || aLevel !== 5'd0) begin errors++; $display("[TB] FAIL underflow_set got unf=%b level=%0d want 1 0", aUnf, aLevel); end
    endtask

    task automatic test_clr_err();
        aClr = 1'b1;
        tick();
        aClr = 1'b0;
        checks++; if (aOvf !== 1'b0 || aUnf !== 1'b0) begin errors++; $display("[TB] FAIL clr_err got ovf=%b unf=%b want 0 0", aOvf, aUnf); end
    endtask

    task automatic test_simul_rw_full();
        fillA(16, 1);
        aWr  = 1'b1;
        aRd  = 1'b1;
        aDin = 8'h55;
        tick();
        aWr  = 1'b0;
        aRd  = 1'b0;
        checks++; if (aLevel !== 5'd15) begin errors++; $display("[TB] FAIL simul_level got %0d want 15", aLevel); end
        checks++; if (aOvf !== 1'b1) begin errors++; $display("[TB] FAIL simul_ovf got %b want 1", aOvf); end
        checks++; if (aDout !== 8'h02) begin errors++; $display("[TB] FAIL simul_head got %h want 02", aDout); end
    endtask

    task automatic test_flush();
        aFlush = 1'b1;
        tick();
        aFlush = 1'b0;
        fillA(7, 8'h30);
        checks++; if (aLevel !== 5'd7) begin errors++; $display("[TB] FAIL flush_pre_level got %0d want 7", aLevel); end
        aFlush = 1'b1;
        aWr    = 1'b1;
        aDin   = 8'hEE;
        tick();
        aWr    = 1'b0;
        checks++; if (aLevel !== 5'd0 || aEmpty !== 1'b1) begin errors++; $display("[TB] FAIL flush_wr got level=%0d empty=%b want 0 1", aLevel, aEmpty); end
        checks++; if (aOvf !== 1'b1) begin errors++; $display("[TB] FAIL flush_keeps_ovf got %b want 1", aOvf); end
        aRd = 1'b1;
        tick();
        aRd    = 1'b0;
        aFlush = 1'b0;
        checks++; if (aUnf !== 1'b0 || aLevel !== 5'd0) begin errors++; $display("[TB] FAIL flush_rd_nounf got unf=%b level=%0d want 0 0", aUnf, aLevel); end
    endtask

    task automatic test_clr_collision();
        aClr = 1'b1;
        tick();
        aClr = 1'b0;
        checks++; if (aOvf !== 1'b0) begin errors++; $display("[TB] FAIL clr_ovf got %b want 0", aOvf); end
        fillA(16, 8'h40);
        aWr  = 1'b1;
        aClr = 1'b1;
        tick();
        aWr  = 1'b0;
        aClr = 1'b0;
        checks++; if (aOvf !== 1'b1) begin errors++; $display("[TB] FAIL clr_collision got %b want 1", aOvf); end
    endtask

    task automatic test_wrap();
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 3; k++) begin
                bWr  = 1'b1;
                bDin = 8'(p * 16 + k + 1);
                tick();
                checks++; if (bLevel !== 3'(k + 1)) begin errors++; $display("[TB] FAIL wrap_wlevel got %0d want %0d", bLevel, k + 1); end
            end
            bWr = 1'b0;
            for (int k = 0; k < 3; k++) begin
                checks++; if (bDout !== 8'(p * 16 + k + 1)) begin errors++; $display("[TB] FAIL wrap_data got %h want %h", bDout, 8'(p * 16 + k + 1)); end
                bRd = 1'b1;
                tick();
                checks++; if (bLevel !== 3'(2 - k)) begin errors++; $display("[TB] FAIL wrap_rlevel got %0d want %0d", bLevel, 2 - k); end
            end
            bRd = 1'b0;
        end
        checks++; if (bEmpty !== 1'b1 || bOvf !== 1'b0 || bUnf !== 1'b0) begin errors++; $display("[TB] FAIL wrap_end got empty=%b ovf=%b unf=%b want 1 0 0", bEmpty, bOvf, bUnf); end
    endtask

    task automatic test_registered();
        cWr  = 1'b1;
        cDin = 8'h11;
        tick();
        cDin = 8'h22;
        tick();
        cWr  = 1'b0;
        checks++; if (cDv !== 1'b0 || cLevel !== 3'd2) begin errors++; $display("[TB] FAIL reg_prefill got dv=%b level=%0d want 0 2", cDv, cLevel); end
        cRd = 1'b1;
        tick();
        checks++; if (cDout !== 8'h11 || cDv !== 1'b1) begin errors++; $display("[TB] FAIL reg_rd1 got %h/%b want 11/1", cDout, cDv); end
        tick();
        checks++; if (cDout !== 8'h22 || cDv !== 1'b1) begin errors++; $display("[TB] FAIL reg_rd2 got %h/%b want 22/1", cDout, cDv); end
        tick();
        cRd = 1'b0;
        checks++; if (cUnf !== 1'b1 || cDout !== 8'h22 || cDv !== 1'b0) begin errors++; $display("[TB] FAIL reg_rd3 got unf=%b dout=%h dv=%b want 1 22 0", cUnf, cDout, cDv); end
        cFlush = 1'b1;
        tick();
        cFlush = 1'b0;
        checks++; if (cDout !== 8'h22) begin errors++; $display("[TB] FAIL reg_flush_hold got %h want 22", cDout); end
    endtask

    task automatic test_reset_midburst();
        aFlush = 1'b1;
        tick();
        aFlush = 1'b0;
        aWr    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            aDin = 8'(8'h60 + i);
            tick();
        end
        #2;
        rstN = 1'b0;
        #1;
        checks++; if (aLevel !== 5'd0 || aEmpty !== 1'b1 || aFull !== 1'b0) begin errors++; $display("[TB] FAIL midreset_state got level=%0d empty=%b full=%b want 0 1 0", aLevel, aEmpty, aFull); end
        checks++; if (aOvf !== 1'b0 || aUnf !== 1'b0) begin errors++; $display("[TB] FAIL midreset_err got ovf=%b unf=%b want 0 0", aOvf, aUnf); end
        checks++; if (cDout !== 8'h00 || cUnf !== 1'b0) begin errors++; $display("[TB] FAIL midreset_reg got dout=%h unf=%b want 00 0", cDout, cUnf); end
        aWr = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        tick();
        checks++; if (aLevel !== 5'd0) begin errors++; $display("[TB] FAIL postreset_level got %0d want 0", aLevel); end
    endtask

    initial begin
        rstN = 1'b0;
        aFlush = 1'b0; aWr = 1'b0; aRd = 1'b0; aClr = 1'b0; aDin = 8'h00; aAf = 5'd12; aAe = 5'd3;
        bFlush = 1'b0; bWr = 1'b0; bRd = 1'b0; bClr = 1'b0; bDin = 8'h00; bAf = 3'd4; bAe = 3'd1;
        cFlush = 1'b0; cWr = 1'b0; cRd = 1'b0; cClr = 1'b0; cDin = 8'h00; cAf = 3'd3; cAe = 3'd1;

        test_reset();
        test_fill_thresholds();
        test_overflow();
        test_drain();
        test_clr_err();
        test_simul_rw_full();
        test_flush();
        test_clr_collision();
        test_wrap();
        test_registered();
        test_reset_midburst();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
